mfp_ahb_adc_sampler: RTL and testbench

//  AHB-Lite slave giving the CPU a multi-channel view of ADC conversions. Accepts a sample stream
//  (channel tag + data) from the XADC wrapper, keeps per-channel latest raw value and a 2^N-sample

---
 rtl/mfp_ahb_adc_sampler_pkg.sv | 42 ++++
 rtl/mfp_adc_avg_chan.sv | 65 ++++++
 rtl/mfp_ahb_adc_sampler.sv | 156 +++++++++++++++
 tb/tb_mfp_ahb_adc_sampler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_ahb_adc_sampler_pkg.sv
// Purpose: shared register map, CTRL layout and helpers for the ADC sampler slave.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package mfp_ahb_adc_sampler_pkg;

    // Word offsets (byte offset / 4) of the register map
    localparam int H_ADC_CTRL     = 0;   // 0x00
    localparam int H_ADC_STATUS   = 1;   // 0x04
    localparam int H_ADC_THRESH   = 2;   // 0x08
    localparam int H_ADC_CNT      = 3;   // 0x0C
    localparam int H_ADC_RAW_BASE = 4;   // 0x10 + 4*ch
    localparam int H_ADC_AVG_BASE = 12;  // 0x30 + 4*ch

    // CTRL bit indices
    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_AVG_LSB     = 1;
    localparam int CTRL_AVG_MSB     = 3;
    localparam int CTRL_IRQ_EN_BIT  = 4;
    localparam int CTRL_W           = 5;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    // Packed in the same bit order as the CTRL register
    typedef struct packed {
        logic       irq_en;
        logic [2:0] avg_log2;
        logic       enable;
    } ctrl_t;

    // Sample count value at which the current block is completed
    function automatic logic [6:0] blk_last(input logic [2:0] log2);
        logic [7:0] n;
        n = (8'd1 << log2) - 8'd1;
        return n[6:0];
    endfunction

endpackage

// File: rtl/mfp_adc_avg_chan.sv
// Purpose: one ADC channel - latest raw sample plus 2^avg_log2 block average with threshold detect.
// Latency: raw/avg update on the accepting edge; over_set is combinational in the accepting cycle.
// Backpressure: none - every accept is absorbed in one cycle.
//
// Ports: HCLK/HRESET clock and async active-high reset; accept one-cycle strobe for this channel;
//   data sample value; avg_log2 block size exponent; clr drops the block in progress;
//   thresh compare level; raw/avg registered values; over_set high when avg is about to be
//   written with a value above thresh.
module mfp_adc_avg_chan
    import mfp_ahb_adc_sampler_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              accept,
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        avg_log2,
    input  logic              clr,
    input  logic [DATA_W-1:0] thresh,
    output logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] avg,
    output logic              over_set
);

    // 7 extra bits hold 128 full-scale samples without overflow
    localparam int ACC_W = DATA_W + 7;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum;
    logic [6:0]        cnt;
    logic              blk_end;
    logic [DATA_W-1:0] avg_nxt;

    assign sum     = acc + ACC_W'(data);
    // A clear on the same edge discards this sample from the block, so no average is produced
    assign blk_end = accept & ~clr & (cnt == blk_last(avg_log2));
    assign avg_nxt = DATA_W'(sum >> avg_log2);
    assign over_set = blk_end & (avg_nxt > thresh);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            acc <= '0;
            cnt <= '0;
            raw <= '0;
            avg <= '0;
        end else begin
            if (accept) begin
                raw <= data;
            end
            if (clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (blk_end) begin
                avg <= avg_nxt;
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                acc <= sum;
                cnt <= cnt + 7'd1;
            end
        end
    end

endmodule

// File: rtl/mfp_ahb_adc_sampler.sv
// Purpose: AHB-Lite slave exposing per-channel ADC raw/average values, threshold flags and an irq.
// Latency: writes commit at the end of the data phase; HRDATA registered (valid in data phase).
// Backpressure: none - samples are never stalled (dropped when disabled or out of range).
//
// Ports: HCLK/HRESET clock and async active-high reset; HADDR/HTRANS/HWDATA/HWRITE/HSEL AHB slave
//   inputs; HRDATA registered read data; sample_valid/sample_chan/sample_data sample stream from the
//   XADC wrapper; adc_irq registered level interrupt.
module mfp_ahb_adc_sampler
    import mfp_ahb_adc_sampler_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [31:0]       HWDATA,
    input  logic              HWRITE,
    input  logic              HSEL,
    output logic [31:0]       HRDATA,
    input  logic              sample_valid,
    input  logic [2:0]        sample_chan,
    input  logic [DATA_W-1:0] sample_data,
    output logic              adc_irq
);

    localparam logic [3:0] NUM_CH_W = 4'(NUM_CH);

    // Address-phase capture
    logic [ADDR_W-1:0] haddr_d;
    logic [1:0]        htrans_d;
    logic              hwrite_d;
    logic              hsel_d;

    ctrl_t             ctrl;
    ctrl_t             ctrl_new;
    logic [NUM_CH-1:0] status;
    logic [DATA_W-1:0] thresh;
    logic [31:0]       sample_cnt;

    logic              we;
    logic [31:0]       wr_word;
    logic [31:0]       rd_word;
    logic              ctrl_we;
    logic              clr;
    logic [NUM_CH-1:0] status_w1c;
    logic              accept;
    logic [NUM_CH-1:0] over_set;
    logic [DATA_W-1:0] raw_v [NUM_CH];
    logic [DATA_W-1:0] avg_v [NUM_CH];
    logic [31:0]       rd_mux;
    logic              unused_bits;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            haddr_d  <= '0;
            htrans_d <= HTRANS_IDLE;
            hwrite_d <= 1'b0;
            hsel_d   <= 1'b0;
        end else begin
            haddr_d  <= HADDR;
            htrans_d <= HTRANS;
            hwrite_d <= HWRITE;
            hsel_d   <= HSEL;
        end
    end

    assign we       = hsel_d & hwrite_d & (htrans_d != HTRANS_IDLE);
    assign wr_word  = 32'(haddr_d[ADDR_W-1:2]);
    assign rd_word  = 32'(HADDR[ADDR_W-1:2]);
    assign ctrl_new = ctrl_t'(HWDATA[CTRL_W-1:0]);
    assign ctrl_we  = we & (wr_word == 32'(H_ADC_CTRL));

    // Block in progress is abandoned when its size changes or sampling is switched off
    assign clr = ctrl_we & ((ctrl_new.avg_log2 != ctrl.avg_log2) | ~ctrl_new.enable);

    assign status_w1c = (we & (wr_word == 32'(H_ADC_STATUS))) ? HWDATA[NUM_CH-1:0] : '0;

    assign accept = sample_valid & ctrl.enable & ({1'b0, sample_chan} < NUM_CH_W);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mfp_adc_avg_chan #(
            .DATA_W (DATA_W)
        ) u_chan (
            .HCLK     (HCLK),
            .HRESET   (HRESET),
            .accept   (accept & (sample_chan == 3'(g))),
            .data     (sample_data),
            .avg_log2 (ctrl.avg_log2),
            .clr      (clr),
            .thresh   (thresh),
            .raw      (raw_v[g]),
            .avg      (avg_v[g]),
            .over_set (over_set[g])
        );
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ctrl       <= '0;
            status     <= '0;
            thresh     <= '1;
            sample_cnt <= '0;
            adc_irq    <= 1'b0;
        end else begin
            if (ctrl_we) begin
                ctrl <= ctrl_new;
            end
            if (we & (wr_word == 32'(H_ADC_THRESH))) begin
                thresh <= HWDATA[DATA_W-1:0];
            end
            // A new flag on the same edge as its clear survives
            status <= (status & ~status_w1c) | over_set;
            if (accept) begin
                sample_cnt <= sample_cnt + 32'd1;
            end
            adc_irq <= ctrl.irq_en & (|status);
        end
    end

    always_comb begin
        rd_mux = '0;
        if (rd_word == 32'(H_ADC_CTRL)) begin
            rd_mux = 32'(ctrl);
        end else if (rd_word == 32'(H_ADC_STATUS)) begin
            rd_mux = 32'(status);
        end else if (rd_word == 32'(H_ADC_THRESH)) begin
            rd_mux = 32'(thresh);
        end else if (rd_word == 32'(H_ADC_CNT)) begin
            rd_mux = sample_cnt;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_word == 32'(H_ADC_RAW_BASE + i)) begin
                rd_mux = 32'(raw_v[i]);
            end
            if (rd_word == 32'(H_ADC_AVG_BASE + i)) begin
                rd_mux = 32'(avg_v[i]);
            end
        end
    end

    // Read data follows the address every cycle; a read racing a write commit sees the old value
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HRDATA <= '0;
        end else begin
            HRDATA <= rd_mux;
        end
    end

    // Byte-lane bits and upper write data are not decoded
    assign unused_bits = ^{HWDATA, HADDR[1:0], haddr_d[1:0]};

endmodule

// File: tb/tb_mfp_ahb_adc_sampler.sv
// Purpose: self-checking bench for mfp_ahb_adc_sampler (vector tables, corner sequences, random vs model).
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: n/a.
module tb_mfp_ahb_adc_sampler;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 12;
    localparam int ADDR_W = 8;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic [31:0]       HWDATA;
    logic              HWRITE;
    logic              HSEL;
    logic [31:0]       HRDATA;
    logic              sample_valid;
    logic [2:0]        sample_chan;
    logic [DATA_W-1:0] sample_data;
    logic              adc_irq;

    mfp_ahb_adc_sampler #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HADDR        (HADDR),
        .HTRANS       (HTRANS),
        .HWDATA       (HWDATA),
        .HWRITE       (HWRITE),
        .HSEL         (HSEL),
        .HRDATA       (HRDATA),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .sample_data  (sample_data),
        .adc_irq      (adc_irq)
    );

    always #5 HCLK = ~HCLK;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // All bus tasks start and end just after a falling edge
    task automatic ahb_wr(input logic [7:0] a, input logic [31:0] d);
        HADDR = a; HWRITE = 1'b1; HSEL = 1'b1; HTRANS = 2'b10;
        @(negedge HCLK);
        HWDATA = d; HWRITE = 1'b0; HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
    endtask

    task automatic ahb_rd(input logic [7:0] a, output logic [31:0] d);
        HADDR = a; HWRITE = 1'b0; HSEL = 1'b1; HTRANS = 2'b10;
        @(negedge HCLK);
        d = HRDATA;
        HSEL = 1'b0; HTRANS = 2'b00;
    endtask

    task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        ahb_rd(a, d);
        check(name, d, exp);
    endtask

    task automatic smp(input logic [2:0] ch, input logic [11:0] d);
        sample_valid = 1'b1; sample_chan = ch; sample_data = d;
        @(negedge HCLK);
        sample_valid = 1'b0;
    endtask

    // ---------------- reference model: per-channel list of samples in the open block
    logic [31:0] m_cnt;
    logic [11:0] m_raw [NUM_CH];
    logic [11:0] m_avg [NUM_CH];
    logic [11:0] m_thr;
    logic [3:0]  m_st;
    int          m_log2;
    bit          m_en;
    int unsigned m_q [NUM_CH][$];

    function automatic void m_reset();
        m_cnt = 0; m_thr = 12'hFFF; m_st = 0; m_log2 = 0; m_en = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_raw[c] = 0; m_avg[c] = 0; m_q[c].delete();
        end
    endfunction

    function automatic void m_ctrl(input int log2, input bit en);
        if (log2 != m_log2 || !en)
            for (int c = 0; c < NUM_CH; c++) m_q[c].delete();
        m_log2 = log2; m_en = en;
    endfunction

    function automatic void m_sample(input int ch, input int unsigned d);
        int unsigned s;
        if (!m_en || ch >= NUM_CH) return;
        m_raw[ch] = 12'(d);
        m_cnt++;
        m_q[ch].push_back(d);
        if (m_q[ch].size() == (1 << m_log2)) begin
            s = 0;
            foreach (m_q[ch][k]) s += m_q[ch][k];
            m_avg[ch] = 12'(s / (1 << m_log2));
            if (m_avg[ch] > m_thr) m_st[ch] = 1'b1;
            m_q[ch].delete();
        end
    endfunction

    // ---------------- vector tables
    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        bit          vld;
        logic [2:0]  ch;
        logic [11:0] d;
        logic [7:0]  addr;
        logic [31:0] exp;
    } smp_vec_t;

    rd_vec_t  rst_tab [15];
    smp_vec_t smp_tab [12];

    task automatic check_reset_table(input string tag);
        for (int i = 0; i < 15; i++)
            rd_check($sformatf("%s_rd%02h", tag, rst_tab[i].addr), rst_tab[i].addr, rst_tab[i].exp);
    endtask

    task automatic run_smp_vec(input int i);
        if (smp_tab[i].vld) smp(smp_tab[i].ch, smp_tab[i].d);
        rd_check($sformatf("vec%0d", i), smp_tab[i].addr, smp_tab[i].exp);
    endtask

    initial begin
        logic [31:0] d;

        rst_tab = '{
            '{8'h00, 32'h0}, '{8'h04, 32'h0}, '{8'h08, 32'hFFF}, '{8'h0C, 32'h0},
            '{8'h10, 32'h0}, '{8'h14, 32'h0}, '{8'h18, 32'h0}, '{8'h1C, 32'h0},
            '{8'h30, 32'h0}, '{8'h34, 32'h0}, '{8'h38, 32'h0}, '{8'h3C, 32'h0},
            '{8'h24, 32'h0}, '{8'h50, 32'h0}, '{8'hFC, 32'h0}
        };
        // Enabled with avg_log2=0 for 0..9, then disabled for 10..11
        smp_tab = '{
            '{1'b1, 3'd2, 12'h123, 8'h18, 32'h123},
            '{1'b0, 3'd0, 12'h000, 8'h38, 32'h123},
            '{1'b0, 3'd0, 12'h000, 8'h0C, 32'h1},
            '{1'b1, 3'd0, 12'hABC, 8'h30, 32'hABC},
            '{1'b1, 3'd3, 12'hFFF, 8'h1C, 32'hFFF},
            '{1'b1, 3'd5, 12'h777, 8'h0C, 32'h3},
            '{1'b0, 3'd0, 12'h000, 8'h24, 32'h0},
            '{1'b1, 3'd1, 12'h001, 8'h34, 32'h1},
            '{1'b0, 3'd0, 12'h000, 8'h08, 32'hFFF},
            '{1'b0, 3'd0, 12'h000, 8'h04, 32'h0},
            '{1'b1, 3'd2, 12'h999, 8'h18, 32'h123},
            '{1'b0, 3'd0, 12'h000, 8'h0C, 32'h4}
        };

        HRESET = 1'b1; HADDR = '0; HTRANS = 2'b00; HWDATA = '0; HWRITE = 1'b0; HSEL = 1'b0;
        sample_valid = 1'b0; sample_chan = '0; sample_data = '0;
        @(negedge HCLK); @(negedge HCLK);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_irq", {31'b0, adc_irq}, 32'h0);
        HRESET = 1'b0;
        @(negedge HCLK);
        check_reset_table("rst");

        // Single-sample average and disable
        ahb_wr(8'h00, 32'h1);
        for (int i = 0; i < 10; i++) run_smp_vec(i);
        ahb_wr(8'h00, 32'h0);
        for (int i = 10; i < 12; i++) run_smp_vec(i);

        // 8-sample block: no average until the 8th sample
        ahb_wr(8'h00, 32'h7);
        for (int k = 0; k < 7; k++) smp(3'd0, 12'(12'h100 + k));
        rd_check("avg0_after7", 8'h30, 32'hABC);
        smp(3'd0, 12'h107);
        rd_check("avg0_after8", 8'h30, 32'h103);
        rd_check("status_avg8", 8'h04, 32'h0);

        // Threshold is strict; irq lags STATUS by one cycle
        ahb_wr(8'h08, 32'h200);
        ahb_wr(8'h00, 32'h11);
        smp(3'd1, 12'h200);
        rd_check("status_eq_thr", 8'h04, 32'h0);
        check("irq_eq_thr", {31'b0, adc_irq}, 32'h0);
        smp(3'd1, 12'h201);
        check("irq_same_cycle", {31'b0, adc_irq}, 32'h0);
        @(negedge HCLK);
        check("irq_next_cycle", {31'b0, adc_irq}, 32'h1);
        rd_check("status_over", 8'h04, 32'h2);

        // W1C on the same edge as a new over-threshold average: set wins
        HADDR = 8'h04; HWRITE = 1'b1; HSEL = 1'b1; HTRANS = 2'b10;
        @(negedge HCLK);
        HWDATA = 32'h2; HWRITE = 1'b0; HSEL = 1'b0; HTRANS = 2'b00;
        sample_valid = 1'b1; sample_chan = 3'd1; sample_data = 12'h300;
        @(negedge HCLK);
        sample_valid = 1'b0;
        rd_check("status_set_wins", 8'h04, 32'h2);
        ahb_wr(8'h04, 32'h2);
        check("irq_still_high", {31'b0, adc_irq}, 32'h1);
        rd_check("status_cleared", 8'h04, 32'h0);
        check("irq_dropped", {31'b0, adc_irq}, 32'h0);

        // Read racing a write commit to the same register sees the old value
        HADDR = 8'h08; HWRITE = 1'b1; HSEL = 1'b1; HTRANS = 2'b10;
        @(negedge HCLK);
        HWDATA = 32'h345; HWRITE = 1'b0; HSEL = 1'b1; HTRANS = 2'b10;
        @(negedge HCLK);
        check("rd_during_wr_old", HRDATA, 32'h200);
        HSEL = 1'b0; HTRANS = 2'b00;
        rd_check("rd_after_wr_new", 8'h08, 32'h345);

        // Reset mid-averaging with irq asserted
        ahb_wr(8'h00, 32'h13);
        smp(3'd1, 12'h400);
        smp(3'd1, 12'h400);
        smp(3'd2, 12'h050);
        @(negedge HCLK);
        check("irq_before_reset", {31'b0, adc_irq}, 32'h1);
        HRESET = 1'b1;
        #1;
        check("irq_async_reset", {31'b0, adc_irq}, 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        check_reset_table("mid");
        ahb_wr(8'h00, 32'h3);
        smp(3'd2, 12'h010);
        rd_check("no_partial_avg", 8'h38, 32'h0);

        // Randomized back-to-back sample bursts against the model
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        m_reset();
        for (int r = 0; r < 8; r++) begin
            int  lg;
            bit  en;
            int  thr;
            lg  = $urandom_range(0, 3);
            en  = ($urandom_range(0, 3) != 0);
            thr = $urandom_range(12'h300, 12'hC00);
            ahb_wr(8'h00, 32'((lg << 1) | int'(en)));
            m_ctrl(lg, en);
            ahb_wr(8'h08, 32'(thr));
            m_thr = 12'(thr);
            for (int c = 0; c < 60; c++) begin
                bit          v;
                int          ch;
                int unsigned dv;
                v  = ($urandom_range(0, 7) != 0);
                ch = $urandom_range(0, 4);
                dv = $urandom_range(0, 12'hFFF);
                sample_valid = v; sample_chan = 3'(ch); sample_data = 12'(dv);
                @(negedge HCLK);
                if (v) m_sample(ch, dv);
            end
            sample_valid = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                rd_check($sformatf("rnd%0d_raw%0d", r, c), 8'(8'h10 + 4 * c), 32'(m_raw[c]));
                rd_check($sformatf("rnd%0d_avg%0d", r, c), 8'(8'h30 + 4 * c), 32'(m_avg[c]));
            end
            rd_check($sformatf("rnd%0d_cnt", r), 8'h0C, m_cnt);
            rd_check($sformatf("rnd%0d_status", r), 8'h04, 32'(m_st));
            ahb_wr(8'h04, 32'hF);
            m_st = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
